ir_nec_decoder: RTL and testbench
=================================

# ir_nec_decoder

Synthesizable NEC infrared frame receiver, the receive-side counterpart of the IR NEC bench driver. It samples the raw IR demodulator pin and measures pulse durations in ticks of a programmable period. It decodes address/data with complement checking and presents each good frame to the controller logic as a one-cycle strobe with held address/data registers.

## Interface
- No parameters. Widths are fixed by constants in `ir_nec_pkg`.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: decoder on. Low forces IDLE and suppresses all strobes.
- `polarity` in 1: active level of `ir_in`. Idle level is `~polarity`.
- `tick_period` in 16: clk cycles per NEC tick T. Legal range 4..65535.
- `ir_in` in 1: asynchronous IR pin.
- `frame_valid` out 1: one-cycle pulse on an accepted frame.
- `frame_addr` out 8: address of the last accepted frame.
- `frame_data` out 8: data of the last accepted frame.
- `frame_error` out 1: one-cycle pulse on an aborted or corrupt frame.
- `enable`, `polarity` and `tick_period` are static while `enable`=1. Changing them mid-frame is unsupported.

## Operation
- Frame format, durations in T:
  - start: active 16, idle 8.
  - 32 bits, LSB first: addr, ~addr, data, ~data.
  - bit 0: active 1, idle 1. bit 1: active 1, idle 3.
  - stop: active 1, then idle.
- Front end:
  - 2-flop synchronizer, then XOR with `~polarity` giving `act` (1 = active).
  - Registered edge detect produces `rise`/`fall` of `act`.
- Duration measure, `d`:
  - Prescaler counts clk cycles and emits a tick strobe every `tick_period` cycles.
  - On every edge the prescaler reloads with `tick_period>>1` and `d` clears to 0, so `d` is the duration rounded to the nearest T.
  - `d` is 5 bits and saturates at 31.
- FSM (`d` is the value at the edge):
  - IDLE: `rise` → START_ACT. A level already active at enable/reset does not trigger.
  - START_ACT: on `fall`, `d` in 12..20 → START_IDLE, else error. `d`>20 while active → error.
  - START_IDLE: on `rise`, `d` in 6..10 → BIT_ACT with bit_cnt=0, else error. `d`>10 → error (timeout).
  - BIT_ACT: on `fall`, `d` in 1..2 is required, else error.
    - bit_cnt<32 → BIT_IDLE.
    - bit_cnt=32 (stop pulse) → CHECK.
    - `d`>2 while active → error.
  - BIT_IDLE: on `rise`, `d` 1..2 shifts in 0 and `d` 3..4 shifts in 1, then bit_cnt+1 → BIT_ACT. Other `d`, or `d`>4 while idle → error.
  - CHECK: one cycle.
    - If sr[15:8]==~sr[7:0] and sr[31:24]==~sr[23:16]: load `frame_addr`/`frame_data`, pulse `frame_valid`.
    - Otherwise pulse `frame_error`.
    - → IDLE.
  - error: pulse `frame_error` for one cycle → IDLE.
- Shift register sr[31:0]: shift right, new bit into sr[31]. After 32 bits, sr[7:0]=addr.
- bit_cnt is 6 bits. Bit 32 is never shifted; that pulse is the stop.
- `enable` falling mid-frame → IDLE silently, no `frame_error`.

## Timing
- Reset values: `frame_valid`=0, `frame_error`=0, `frame_addr`=0x00, `frame_data`=0x00; FSM=IDLE, sr=0, bit_cnt=0, `d`=0.
- Reset mid-frame: frame is discarded, no strobes.
- Latency: stop-pulse trailing transition sampled at clk edge N → `frame_valid` high during cycle N+4 (2 sync + edge reg + CHECK).
- `frame_addr`/`frame_data` update in the same cycle `frame_valid` rises and hold until the next accepted frame.
- An error frame leaves them unchanged.
- `frame_valid` and `frame_error` are never high together.
- Back-to-back frames: the decoder is in IDLE again before the next start's `rise`. Minimum inter-frame idle is 2T.
- Timeout detection: error within 1 tick after `d` passes its window limit.

## Structure
- `ir_nec_pkg` holds:
  - FSM state enum: IDLE, START_ACT, START_IDLE, BIT_ACT, BIT_IDLE, CHECK.
  - Window constants: START_ACT 12/20, START_IDLE 6/10, PULSE 1/2, ZERO 1/2, ONE 3/4, D_MAX 31.
  - Widths: TICK_W=16, D_W=5, CNT_W=6.
- Sub-module `ir_tick_gen`: prescaler with reload-to-half on edge, tick strobe output, and the saturating `d` counter.

## Test plan
- `tick_period`=10, `polarity`=0, driver sends addr 0x5A, data 0xC3 → one `frame_valid`, `frame_addr`=0x5A, `frame_data`=0xC3, no `frame_error`.
- `polarity`=1, `tick_period`=4, frames 0x00→0xFF then 0xFF→0x00 back-to-back with 2T gap → two `frame_valid` pulses with matching values.
- Frame with ~data byte bit 3 flipped → exactly one `frame_error` 4 cycles after the stop trailing edge; outputs keep their previous values.
- Start active of 8T, then a bit idle stretched to 6T in a second frame → `frame_error` for each, no `frame_valid`.
- Edge jitter ±0.4T on every edge of a 0x12→0x34 frame → `frame_valid` with 0x12/0x34.
- `rst_n` pulsed low after bit 10, and `enable` dropped after bit 20 in another frame → no strobes, outputs 0x00. The next clean frame decodes correctly.

Source files
------------

// File: rtl/ir_nec_pkg.sv
// Shared constants and types for the NEC IR frame receiver.
// Holds the FSM state enum, the duration windows (in NEC ticks T),
// the datapath widths and a small window-compare helper.
package ir_nec_pkg;

    localparam int unsigned TickW = 16;
    localparam int unsigned DW    = 5;
    localparam int unsigned CntW  = 6;

    // Duration windows, in rounded ticks of T.
    localparam logic [DW-1:0] StartActMin  = 5'd12;
    localparam logic [DW-1:0] StartActMax  = 5'd20;
    localparam logic [DW-1:0] StartIdleMin = 5'd6;
    localparam logic [DW-1:0] StartIdleMax = 5'd10;
    localparam logic [DW-1:0] PulseMin     = 5'd1;
    localparam logic [DW-1:0] PulseMax     = 5'd2;
    localparam logic [DW-1:0] ZeroMin      = 5'd1;
    localparam logic [DW-1:0] ZeroMax      = 5'd2;
    localparam logic [DW-1:0] OneMin       = 5'd3;
    localparam logic [DW-1:0] OneMax       = 5'd4;
    localparam logic [DW-1:0] DMax         = 5'd31;

    localparam logic [CntW-1:0] NumBits = 6'd32;

    typedef enum logic [2:0] {
        StIdle,
        StStartAct,
        StStartIdle,
        StBitAct,
        StBitIdle,
        StCheck
    } nec_state_e;

    function automatic logic in_win(input logic [DW-1:0] d,
                                    input logic [DW-1:0] lo,
                                    input logic [DW-1:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Tick prescaler and pulse-duration counter.
// Ports:
//   clk_i, rst_ni   : clock, async active-low reset
//   clear_i         : edge strobe; restarts the measurement
//   tick_period_i   : clk cycles per tick T
//   tick_o          : one-cycle tick strobe
//   d_o             : ticks since the last edge, rounded to nearest, saturating
module ir_tick_gen
    import ir_nec_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [TickW-1:0] tick_period_i,
    output logic             tick_o,
    output logic [DW-1:0]    d_o
);

    logic [TickW-1:0] presc_q, presc_d;
    logic [DW-1:0]    d_q, d_d;
    logic             tick;

    // Reloading with half a period on each edge places the first tick at
    // T/2, so the tick count at the next edge is the duration rounded.
    always_comb begin
        tick    = 1'b0;
        presc_d = presc_q - TickW'(1);
        d_d     = d_q;
        if (clear_i) begin
            presc_d = tick_period_i >> 1;
            d_d     = '0;
        end else if (presc_q <= TickW'(1)) begin
            tick    = 1'b1;
            presc_d = tick_period_i;
            if (d_q != DMax) begin
                d_d = d_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            d_q     <= '0;
        end else begin
            presc_q <= presc_d;
            d_q     <= d_d;
        end
    end

    assign tick_o = tick;
    assign d_o    = d_q;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC infrared frame receiver.
// Synchronises the raw IR pin, measures pulse durations in ticks of
// tick_period_i clocks, decodes the 32-bit frame and checks complements.
// Ports:
//   clk_i, rst_ni  : clock, async active-low reset
//   enable_i       : decoder on; low forces idle and suppresses strobes
//   polarity_i     : active level of ir_in_i
//   tick_period_i  : clk cycles per NEC tick T (4..65535)
//   ir_in_i        : asynchronous IR demodulator pin
//   frame_valid_o  : one-cycle pulse on an accepted frame
//   frame_addr_o   : address of the last accepted frame
//   frame_data_o   : data of the last accepted frame
//   frame_error_o  : one-cycle pulse on an aborted or corrupt frame
module ir_nec_decoder
    import ir_nec_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        polarity_i,
    input  logic [15:0] tick_period_i,
    input  logic        ir_in_i,
    output logic        frame_valid_o,
    output logic [7:0]  frame_addr_o,
    output logic [7:0]  frame_data_o,
    output logic        frame_error_o
);

    logic sync1_q, sync2_q, act, act_q, rise_q, fall_q;

    assign act = sync2_q ^ ~polarity_i;

    // act_q resets/holds at 1 so a level already active at reset or enable
    // never looks like a rise; the resulting spurious fall is ignored in idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            act_q   <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= ir_in_i;
            sync2_q <= sync1_q;
            if (!enable_i) begin
                act_q  <= 1'b1;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                act_q  <= act;
                rise_q <= act & ~act_q;
                fall_q <= ~act & act_q;
            end
        end
    end

    logic          tick;
    logic [DW-1:0] d;

    ir_tick_gen u_tick_gen (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (rise_q | fall_q),
        .tick_period_i (tick_period_i),
        .tick_o        (tick),
        .d_o           (d)
    );

    nec_state_e      state_q;
    logic [31:0]     sr_q;
    logic [CntW-1:0] bit_cnt_q;
    logic            valid_q, error_q;
    logic [7:0]      addr_q, data_q;

    // Timeouts fire on the tick that would carry d past a window limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            if (!enable_i) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (rise_q) state_q <= StStartAct;
                    end
                    StStartAct: begin
                        if (fall_q) begin
                            if (in_win(d, StartActMin, StartActMax)) begin
                                state_q <= StStartIdle;
                            end else begin
                                error_q <= 1'b1;
                                state_q <= StIdle;
                            end
                        end else if (tick && d >= StartActMax) begin
                            error_q <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    StStartIdle: begin
                        if (rise_q) begin
                            if (in_win(d, StartIdleMin, StartIdleMax)) begin
                                bit_cnt_q <= '0;
                                state_q   <= StBitAct;
                            end else begin
                                error_q <= 1'b1;
                                state_q <= StIdle;
                            end
                        end else if (tick && d >= StartIdleMax) begin
                            error_q <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    StBitAct: begin
                        if (fall_q) begin
                            if (!in_win(d, PulseMin, PulseMax)) begin
                                error_q <= 1'b1;
                                state_q <= StIdle;
                            end else if (bit_cnt_q == NumBits) begin
                                state_q <= StCheck;  // this was the stop pulse
                            end else begin
                                state_q <= StBitIdle;
                            end
                        end else if (tick && d >= PulseMax) begin
                            error_q <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    StBitIdle: begin
                        if (rise_q) begin
                            if (in_win(d, ZeroMin, ZeroMax) || in_win(d, OneMin, OneMax)) begin
                                sr_q      <= {(d >= OneMin), sr_q[31:1]};
                                bit_cnt_q <= bit_cnt_q + CntW'(1);
                                state_q   <= StBitAct;
                            end else begin
                                error_q <= 1'b1;
                                state_q <= StIdle;
                            end
                        end else if (tick && d >= OneMax) begin
                            error_q <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    StCheck: begin
                        if (sr_q[15:8] == ~sr_q[7:0] && sr_q[31:24] == ~sr_q[23:16]) begin
                            addr_q  <= sr_q[7:0];
                            data_q  <= sr_q[23:16];
                            valid_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign frame_valid_o = valid_q;
    assign frame_error_o = error_q;
    assign frame_addr_o  = addr_q;
    assign frame_data_o  = data_q;

endmodule

// File: tb/tb_ir_nec_decoder.sv
module tb_ir_nec_decoder;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        polarity;
    logic [15:0] tick_period;
    logic        ir_in;
    logic        frame_valid;
    logic [7:0]  frame_addr;
    logic [7:0]  frame_data;
    logic        frame_error;

    ir_nec_decoder dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (enable),
        .polarity_i    (polarity),
        .tick_period_i (tick_period),
        .ir_in_i       (ir_in),
        .frame_valid_o (frame_valid),
        .frame_addr_o  (frame_addr),
        .frame_data_o  (frame_data),
        .frame_error_o (frame_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int tper = 10;
    int v0, e0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_word(input logic [7:0] a, input logic [7:0] d);
        return {~d, d, ~a, a};
    endfunction

    // Hold a level for t ticks, optionally jittered by up to +/-jit cycles.
    task automatic drive(input bit active, input int t, input int jit);
        int cyc;
        cyc = t * tper;
        if (jit > 0) cyc = cyc + int'($urandom_range(2 * jit)) - jit;
        ir_in = active ? polarity : ~polarity;
        repeat (cyc) @(negedge clk);
    endtask

    // Sends start + nbits bits (+ stop when nbits==32); returns with the line idle.
    task automatic send_frame(input logic [31:0] word, input int nbits, input int start_act,
                              input int stretch_bit, input int stretch_t, input int jit);
        drive(1'b1, start_act, jit);
        drive(1'b0, 8, jit);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b1, 1, jit);
            if (i == stretch_bit) drive(1'b0, stretch_t, jit);
            else drive(1'b0, word[i] ? 3 : 1, jit);
        end
        if (nbits == 32) drive(1'b1, 1, jit);
        ir_in = ~polarity;
    endtask

    always @(negedge clk) begin
        if (frame_valid) begin
            valid_cnt++;
            chk("valid_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                chk("addr_data", 32'({frame_addr, frame_data}), 32'(mon_exp));
            end
            chk("valid_error_exclusive", 32'(frame_error), 32'd0);
        end
        if (frame_error) err_cnt++;
    end

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        enable = 1'b1;
        polarity = 1'b0;
        tick_period = 16'd10;
        tper = 10;
        ir_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_error", 32'(frame_error), 32'd0);
        chk("rst_addr", 32'(frame_addr), 32'h00);
        chk("rst_data", 32'(frame_data), 32'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Clean frame, T=10, active-low.
        v0 = valid_cnt; e0 = err_cnt;
        exp_q.push_back({8'h5A, 8'hC3});
        send_frame(mk_word(8'h5A, 8'hC3), 32, 16, -1, 0, 0);
        repeat (30) @(negedge clk);
        chk("t1_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("t1_err_cnt", 32'(err_cnt - e0), 32'd0);
        chk("t1_addr", 32'(frame_addr), 32'h5A);
        chk("t1_data", 32'(frame_data), 32'hC3);

        // ~data bit 3 flipped: error exactly 4 cycles after the stop trailing edge.
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(mk_word(8'h21, 8'h87) ^ 32'h0800_0000, 32, 16, -1, 0, 0);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 chk("t3_err_n3", 32'(frame_error), 32'd0);
        @(posedge clk);
        #1 chk("t3_err_n4", 32'(frame_error), 32'd1);
        repeat (30) @(negedge clk);
        chk("t3_err_cnt", 32'(err_cnt - e0), 32'd1);
        chk("t3_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        chk("t3_addr_kept", 32'(frame_addr), 32'h5A);
        chk("t3_data_kept", 32'(frame_data), 32'hC3);

        // +/-0.4T jitter on every duration.
        v0 = valid_cnt; e0 = err_cnt;
        exp_q.push_back({8'h12, 8'h34});
        send_frame(mk_word(8'h12, 8'h34), 32, 16, -1, 0, 4);
        repeat (30) @(negedge clk);
        chk("t5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("t5_err_cnt", 32'(err_cnt - e0), 32'd0);
        chk("t5_addr", 32'(frame_addr), 32'h12);
        chk("t5_data", 32'(frame_data), 32'h34);

        // Short start pulse (8T).
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(mk_word(8'hAA, 8'h55), 32, 8, -1, 0, 0);
        repeat (60) @(negedge clk);
        chk("t4a_err_seen", 32'(err_cnt > e0), 32'd1);
        chk("t4a_valid_cnt", 32'(valid_cnt - v0), 32'd0);

        // Bit 5 idle stretched to 6T.
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(mk_word(8'hAA, 8'h55), 32, 16, 5, 6, 0);
        repeat (60) @(negedge clk);
        chk("t4b_err_seen", 32'(err_cnt > e0), 32'd1);
        chk("t4b_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        chk("t4b_addr_kept", 32'(frame_addr), 32'h12);
        chk("t4b_data_kept", 32'(frame_data), 32'h34);

        // Reset after bit 10, then enable dropped after bit 20.
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(mk_word(8'h77, 8'h88), 10, 16, -1, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        send_frame(mk_word(8'h99, 8'h66), 20, 16, -1, 0, 0);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        enable = 1'b1;
        repeat (60) @(negedge clk);
        chk("t6_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        chk("t6_err_cnt", 32'(err_cnt - e0), 32'd0);
        chk("t6_addr", 32'(frame_addr), 32'h00);
        chk("t6_data", 32'(frame_data), 32'h00);

        v0 = valid_cnt; e0 = err_cnt;
        exp_q.push_back({8'hA5, 8'h3C});
        send_frame(mk_word(8'hA5, 8'h3C), 32, 16, -1, 0, 0);
        repeat (30) @(negedge clk);
        chk("t6_next_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("t6_next_addr", 32'(frame_addr), 32'hA5);
        chk("t6_next_data", 32'(frame_data), 32'h3C);

        // Active-high, T=4, back-to-back frames with a 2T gap.
        enable = 1'b0;
        polarity = 1'b1;
        tick_period = 16'd4;
        tper = 4;
        ir_in = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        v0 = valid_cnt; e0 = err_cnt;
        exp_q.push_back({8'h00, 8'hFF});
        send_frame(mk_word(8'h00, 8'hFF), 32, 16, -1, 0, 0);
        repeat (2 * tper) @(negedge clk);
        exp_q.push_back({8'hFF, 8'h00});
        send_frame(mk_word(8'hFF, 8'h00), 32, 16, -1, 0, 0);
        repeat (30) @(negedge clk);
        chk("t2_valid_cnt", 32'(valid_cnt - v0), 32'd2);
        chk("t2_err_cnt", 32'(err_cnt - e0), 32'd0);
        chk("t2_addr", 32'(frame_addr), 32'hFF);
        chk("t2_data", 32'(frame_data), 32'h00);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
